// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operation encoding presented by the execute stage; 6 and 7 are no-ops.
  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } muldiv_state_t;

  // Which radix-2 iteration the datapath performs.
  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   STEP_MUL: {acc, shreg} is the partial product, shreg initially holds the
//             multiplier; add operand when the LSB is set, then shift right.
//   STEP_DIV: restoring division; acc is the partial remainder, shreg shifts
//             the dividend out at the top and the quotient in at the bottom.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  step_mode_t         mode,
  input  logic [WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic [WIDTH-1:0]   shreg,
  output logic [WIDTH-1:0]   acc_next,
  output logic [WIDTH-1:0]   shreg_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic           ge;

  // Select the multiply or divide iteration.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    acc_next   = acc;
    shreg_next = shreg;
    sum        = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
    rem_sh     = {acc, shreg[WIDTH-1]};
    ge         = rem_sh >= {1'b0, operand};
    if (mode == STEP_MUL) begin
      acc_next   = sum[WIDTH:1];
      shreg_next = {sum[0], shreg[WIDTH-1:1]};
    end else begin
      // The remainder stays below the divisor, so a successful subtract fits WIDTH bits.
      acc_next   = ge ? WIDTH'(rem_sh - {1'b0, operand}) : rem_sh[WIDTH-1:0];
      shreg_next = {shreg[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are converted to magnitudes on the start edge, WIDTH radix-2 steps
// run in RUN, and FIXUP applies the signs and commits HI/LO in one edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mf,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t    state;
  logic [CNTW-1:0]  cnt;
  step_mode_t       mode;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] operand;
  logic             neg_res;
  logic             neg_rem;

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] shreg_next;

  muldiv_op_t         op_dec;
  logic               is_muldiv;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode       (mode),
    .acc        (acc),
    .operand    (operand),
    .shreg      (shreg),
    .acc_next   (acc_next),
    .shreg_next (shreg_next)
  );

  assign busy  = (state != IDLE);
  assign stall = busy & (start | mf);

  // Decode the incoming op and form operand magnitudes and signed results.
  always_comb begin
    op_dec    = muldiv_op_t'(op);
    is_muldiv = op_dec inside {MULT, MULTU, DIV, DIVU};
    is_div    = op_dec inside {DIV, DIVU};
    sign_a    = (op_dec inside {MULT, DIV}) & srca[WIDTH-1];
    sign_b    = (op_dec inside {MULT, DIV}) & srcb[WIDTH-1];
    mag_a     = sign_a ? -srca : srca;
    mag_b     = sign_b ? -srcb : srcb;
    prod_fix  = neg_res ? -{acc, shreg} : {acc, shreg};
    quot_fix  = neg_res ? -shreg : shreg;
    rem_fix   = neg_rem ? -acc : acc;
  end

  // Sequencer: load on start, iterate in RUN, commit in FIXUP; flush aborts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      mode    <= STEP_MUL;
      acc     <= '0;
      shreg   <= '0;
      operand <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (is_muldiv) begin
                mode    <= is_div ? STEP_DIV : STEP_MUL;
                acc     <= '0;
                shreg   <= is_div ? mag_a : mag_b;
                operand <= is_div ? mag_b : mag_a;
                // Divide by zero keeps an all-ones quotient regardless of sign.
                neg_res <= (sign_a ^ sign_b) & (~is_div | (|srcb));
                neg_rem <= is_div & sign_a;
                cnt     <= '0;
                state   <= RUN;
              end else if (op_dec == MTHI) begin
                hi <= srca;
              end else if (op_dec == MTLO) begin
                lo <= srca;
              end
            end
          end
          RUN: begin
            acc   <= acc_next;
            shreg <= shreg_next;
            cnt   <= cnt + CNTW'(1);
            if (cnt == CNTW'(WIDTH - 1)) state <= FIXUP;
          end
          FIXUP: begin
            if (mode == STEP_DIV) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with WIDTH=32.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             mf;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .mf    (mf),
    .flush (flush),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one op for a single edge; returns 1 time unit after that edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done rises, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    issue(o, a, b);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int c;
    int stall_err;
    int done_seen;

    reset = 1'b1; start = 1'b0; op = 3'd0; srca = '0; srcb = '0; mf = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // MTHI / MTLO while idle
    issue(MTHI, 32'hCAFEBABE, 32'h0);
    check("mthi_hi", 64'(hi), 64'hCAFEBABE);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    issue(MTLO, 32'h0BADF00D, 32'h0);
    check("mtlo_lo", 64'(lo), 64'h0BADF00D);
    check("mtlo_hi", 64'(hi), 64'hCAFEBABE);

    // Flush in idle discards a same-cycle start
    flush = 1'b1;
    issue(MTLO, 32'h55, 32'h0);
    check("flush_idle_mt", 64'(lo), 64'h0BADF00D);
    issue(MULT, 32'd2, 32'd3);
    flush = 1'b0;
    check("flush_idle_mul", 64'(busy), 64'd0);

    // Multiply / divide vectors
    run_check("mult_neg",  MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_check("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_check("div_neg",   DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_check("divu",      DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    run_check("divu_zero", DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
    run_check("div_zero",  DIV,   32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
    run_check("div_zneg",  DIV,   32'h87654321, 32'd0,        32'h87654321, 32'hFFFFFFFF);
    run_check("div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Stall: MFLO arrives on cycle 5 of a DIVU and is held until busy falls
    issue(DIVU, 32'd1000, 32'd33);
    c = 0;
    stall_err = 0;
    while (busy && c < 100) begin
      if (c == 5) mf = 1'b1;
      #1;
      if (stall !== (c >= 5)) stall_err++;
      @(posedge clk);
      #1;
      c++;
    end
    check("stall_held", 64'(stall_err), 64'd0);
    check("stall_busy_len", 64'(c), 64'(LAT));
    check("stall_release", 64'(stall), 64'd0);
    check("stall_done", 64'(done), 64'd1);
    check("mflo_lo", 64'(lo), 64'd30);
    check("mfhi_hi", 64'(hi), 64'd10);
    mf = 1'b0;
    @(posedge clk);
    #1;

    // Flush on cycle 10 of a MULT
    issue(MULT, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'd10);
    check("flush_lo", 64'(lo), 64'd30);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      @(posedge clk);
      #1;
    end
    check("flush_no_done", 64'(done_seen), 64'd0);

    // Flush during FIXUP suppresses the write
    issue(MULTU, 32'd3, 32'd4);
    repeat (WIDTH) @(posedge clk);
    #1;
    check("fixup_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("fixup_flush_busy", 64'(busy), 64'd0);
    check("fixup_flush_done", 64'(done), 64'd0);
    check("fixup_flush_hi", 64'(hi), 64'd10);
    check("fixup_flush_lo", 64'(lo), 64'd30);

    // Asynchronous reset on cycle 20 of a DIVU
    issue(DIVU, 32'hFFFFFFFF, 32'd3);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("arst_stays_idle", 64'(busy), 64'd0);
    check("arst_hi_kept", 64'(hi), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with an architectural HI/LO register pair.
- Sits in the execute stage of the pipelined datapath and replaces the single-cycle HI/LO path.
- Runs MULT/MULTU/DIV/DIVU over WIDTH+1 cycles and raises a combinational stall to the hazard unit when a dependent instruction arrives while busy.
- Supports abort on pipeline flush.

Parameters:
- WIDTH, 32, operand and HI/LO width (must be ≥4 and even).
- CNTW, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  op valid this cycle (execute stage)
- op  in  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
- srca  in  WIDTH  rs operand (dividend / multiplicand / MTxx data)
- srcb  in  WIDTH  rt operand (divisor / multiplier)
- mf  in  1  MFHI/MFLO present in execute this cycle
- flush  in  1  abort in-flight operation
- stall  out  1  hold pipeline (combinational)
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse, HI/LO just updated by mul/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async): state=IDLE; hi=lo=0; busy=done=0; counter and working registers cleared. Reset mid-operation discards the operation entirely.
- FSM states: IDLE, RUN, FIXUP.
- IDLE, start with MTHI/MTLO: hi (resp. lo) <= srca on that edge; single-cycle; no busy, no done.
- IDLE, start with mul/div: on edge 0, latch magnitudes (signed ops take absolute values), result-sign flags, and op; cnt=0; go RUN.
- RUN: one radix-2 step per edge. Multiply is shift-add over a 2*WIDTH product. Divide is restoring, one quotient bit per step. At cnt==WIDTH-1 go FIXUP.
- FIXUP (edge WIDTH+1):
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend sign.
  - Write {hi,lo}: mul gives hi=upper, lo=lower; div gives lo=quotient, hi=remainder.
  - Go IDLE. done=1 for the following cycle.
- busy = (state != IDLE). busy is high for exactly WIDTH+1 cycles after edge 0.
- stall = busy & (start | mf). A start while busy is ignored by the unit; the pipeline re-presents it because stall holds it.
- hi/lo outputs are only modified in FIXUP or by MTHI/MTLO. Intermediate state is never visible.
- Divide by zero (both signednesses): lo = all ones, hi = original srca. Takes full latency; no exception.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0. This falls out of magnitude arithmetic; no special case.
- flush while busy: next edge state=IDLE, hi/lo unchanged, no done.
- flush while IDLE: nothing to abort; discards any start presented in the same cycle.
- flush and start in the same cycle: flush wins; start ignored.
- flush in the FIXUP cycle: flush wins; no write.

Decomposition:
- muldiv_pkg holds:
  - typedef enum muldiv_op_t (3 bits): MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6, 7 reserved, treated as no-op.
  - typedef enum muldiv_state_t: IDLE, RUN, FIXUP.
- One natural sub-module, muldiv_step: combinational single iteration.
  - Inputs: mode, accumulator, operand, shift register.
  - Outputs: next accumulator and shift register.
  - Instantiated once and driven by the FSM.

Test Plan:
- MULT srca=0xFFFFFFFD (-3), srcb=5 -> done exactly 33 cycles after start edge (WIDTH+1 busy cycles); hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- DIVU/DIV by 0 with srca=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU, assert mf on cycle 5 -> stall high until busy falls. Then MFLO reads the new lo. MTHI while idle -> hi=srca next cycle, no busy.
- Start MULT, flush on cycle 10 -> busy low next cycle, hi/lo keep prior values, no done. Assert reset on cycle 20 of another op -> hi=lo=0 immediately, busy=0.
